// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: each channel divides clk by a
// runtime-programmable period and emits a one-cycle tick, periodic or one-shot.
module tick_gen_multi #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned DEFAULT_MAX = 99_999,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       oneshot,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_max,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] RST_MAX = CNT_W'(DEFAULT_MAX);

  logic [CNT_W-1:0]  cnt_r   [NUM_CH];
  logic [CNT_W-1:0]  max_r   [NUM_CH];
  logic [NUM_CH-1:0] run_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             wr;
    logic             live;
    logic             term;
    logic             shoot;
    logic [CNT_W-1:0] cnt_nxt;
    logic             run_nxt;
    logic             tick_nxt;

    // Out-of-range channel indices match no channel, so those writes vanish.
    assign wr    = cfg_we && (cfg_ch == CH_W'(i));
    assign live  = en[i] && run_r[i];
    assign term  = live && (cnt_r[i] == max_r[i]);
    assign shoot = wr && (cfg_max < cnt_r[i]);

    // Per-channel priority: clr, overshoot clear, terminal, increment, hold.
    always_comb begin
      cnt_nxt  = cnt_r[i];
      run_nxt  = run_r[i];
      tick_nxt = 1'b0;
      if (clr[i]) begin
        cnt_nxt = '0;
        run_nxt = 1'b1;
      end else if (shoot) begin
        cnt_nxt = '0;
      end else if (term) begin
        cnt_nxt  = '0;
        tick_nxt = 1'b1;
        if (oneshot[i]) run_nxt = 1'b0;
      end else if (live) begin
        cnt_nxt = cnt_r[i] + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r[i] <= '0;
        max_r[i] <= RST_MAX;
        run_r[i] <= 1'b1;
        tick[i]  <= 1'b0;
      end else begin
        cnt_r[i] <= cnt_nxt;
        run_r[i] <= run_nxt;
        tick[i]  <= tick_nxt;
        if (wr) max_r[i] <= cfg_max;
      end
    end

    assign busy[i]                 = run_r[i] & en[i];
    assign cnt[i*CNT_W +: CNT_W]   = cnt_r[i];
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi: three channels (so an out-of-range
// cfg_ch exists) and a short reset period to keep the reset test brief.
module tb_tick_gen_multi;

  localparam int unsigned NCH  = 3;
  localparam int unsigned CW   = 27;
  localparam int unsigned DMAX = 49;
  localparam int unsigned CHW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    en, clr, oneshot, tick, busy;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic [CW-1:0]     cfg_max;
  logic [NCH*CW-1:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  tick_gen_multi #(
    .NUM_CH(NCH), .CNT_W(CW), .DEFAULT_MAX(DMAX), .CH_W(CHW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .oneshot(oneshot),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_max(cfg_max),
    .tick(tick), .busy(busy), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] c(input int ch);
    return 64'(cnt[ch*CW +: CW]);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int m);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_max = CW'(m);
    cyc();
    cfg_we  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; clr = '0; oneshot = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_max = '0;

    // Reset state and combinational busy.
    #12;
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_cnt_nz", 64'(cnt != '0), 64'd0);
    en = 3'b111; #1;
    chk("rst_busy", 64'(busy), 64'b111);
    en = '0;
    @(negedge clk) rst = 1'b0;

    // Periodic, ch0 max=3.
    wr(0, 3);
    en = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("per_cnt0", c(0), 64'(k % 4));
      chk("per_tick", 64'(tick), 64'((k % 4) == 0));
    end
    en = '0;

    // One-shot, ch1 max=5.
    wr(1, 5);
    oneshot = 3'b010; en = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("os_tick", 64'(tick), (k == 6) ? 64'b010 : 64'd0);
      chk("os_cnt1", c(1), (k < 6) ? 64'(k) : 64'd0);
      chk("os_busy", 64'(busy), (k < 6) ? 64'b010 : 64'd0);
    end
    clr = 3'b010; cyc(); clr = '0;
    chk("os_rearm_cnt", c(1), 64'd0);
    chk("os_rearm_busy", 64'(busy), 64'b010);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("os2_tick", 64'(tick), (k == 6) ? 64'b010 : 64'd0);
    end
    en = '0; oneshot = '0;

    // Overshoot write: max 99, reach 50, shrink to 10.
    wr(0, 99);
    en = 3'b001;
    repeat (50) cyc();
    chk("ov_pre_cnt", c(0), 64'd50);
    wr(0, 10);
    chk("ov_cnt", c(0), 64'd0);
    chk("ov_tick", 64'(tick), 64'd0);
    for (int k = 1; k <= 22; k++) begin
      cyc();
      chk("ov_per_cnt", c(0), 64'(k % 11));
      chk("ov_per_tick", 64'(tick), 64'((k % 11) == 0));
    end
    en = '0;

    // Clr and write on the same edge, then enable gating with max=4.
    clr = 3'b001; wr(0, 4); clr = '0;
    chk("clrwr_cnt", c(0), 64'd0);
    en = 3'b001;
    cyc(); cyc();
    chk("gate_cnt2", c(0), 64'd2);
    en = '0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("gate_hold", c(0), 64'd2);
      chk("gate_tick", 64'(tick), 64'd0);
    end
    en = 3'b001;
    cyc(); cyc();
    chk("gate_cnt4", c(0), 64'd4);
    chk("gate_notick", 64'(tick), 64'd0);
    cyc();
    chk("gate_term", 64'(tick), 64'b001);
    chk("gate_wrap", c(0), 64'd0);
    en = '0;

    // max=0: tick every enabled cycle.
    wr(0, 0);
    en = 3'b001;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("max0_tick", 64'(tick), 64'b001);
      chk("max0_cnt", c(0), 64'd0);
    end
    en = '0;

    // Write max=7 on the terminal edge of max=3.
    wr(0, 3);
    en = 3'b001;
    cyc(); cyc(); cyc();
    chk("sim_pre_cnt", c(0), 64'd3);
    wr(0, 7);
    chk("sim_tick", 64'(tick), 64'b001);
    chk("sim_cnt", c(0), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("sim_per_tick", 64'(tick), (k == 8) ? 64'b001 : 64'd0);
      chk("sim_per_cnt", c(0), 64'(k % 8));
    end
    en = '0;

    // Out-of-range channel: nothing changes, ch0 keeps period 8.
    wr(3, 1);
    chk("oor_cnt0", c(0), 64'd0);
    chk("oor_cnt1", c(1), 64'd0);
    chk("oor_cnt2", c(2), 64'd0);
    en = 3'b101;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("oor_tick", 64'(tick), (k == 8) ? 64'b001 : 64'd0);
    end
    chk("oor_ch2_cnt", c(2), 64'd8);
    en = '0;

    // Reset mid-count with a tick showing.
    clr = 3'b101; wr(0, 36); clr = '0;
    chk("pre_rst_cnt2", c(2), 64'd0);
    en = 3'b101;
    repeat (37) cyc();
    chk("pre_rst_tick", 64'(tick), 64'b001);
    chk("pre_rst_cnt2b", c(2), 64'd37);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tick", 64'(tick), 64'd0);
    chk("mid_rst_cnt_nz", 64'(cnt != '0), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'b101);
    @(negedge clk) rst = 1'b0;
    repeat (49) cyc();
    chk("post_rst_cnt0", c(0), 64'd49);
    chk("post_rst_notick", 64'(tick), 64'd0);
    cyc();
    chk("post_rst_tick", 64'(tick), 64'b101);
    chk("post_rst_wrap", c(0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
